// File: rtl/cpu_sequencer_if.sv
// Bundle of fetch handshake, ALU flags, control strobes and status between the sequencer and the
// datapath/instruction memory around it.
interface cpu_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        zr;
    logic        ng;
    logic        halt_req;
    logic        mem_req;
    logic [15:0] ir;
    logic        pc_reset;
    logic        pc_load;
    logic        pc_inc;
    logic        a_load;
    logic        a_sel;
    logic        d_load;
    logic        m_write;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    modport master (
        input  instr, instr_valid, zr, ng, halt_req,
        output mem_req, ir, pc_reset, pc_load, pc_inc, a_load, a_sel, d_load, m_write,
               halted, fault, retired
    );

    modport slave (
        output instr, instr_valid, zr, ng, halt_req,
        input  mem_req, ir, pc_reset, pc_load, pc_inc, a_load, a_sel, d_load, m_write,
               halted, fault, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute controller: drives PC, fetch handshake and register/memory strobes
// for a 16-bit CPU with A- and C-instructions.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic            clock,
    input logic            reset,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {StInit, StFetch, StExec, StHalt, StFault} state_e;

    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] ir_q;
    logic [15:0] retired_q;
    logic [7:0]  wait_q;
    logic        fault_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StInit;
            ir_q      <= '0;
            retired_q <= '0;
            wait_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                StInit: state_q <= StFetch;
                StFetch: begin
                    if (bus.instr_valid) begin
                        ir_q    <= bus.instr;
                        wait_q  <= '0;
                        state_q <= StExec;
                    end else if (wait_q == WaitLast) begin
                        fault_q <= 1'b1;
                        state_q <= StFault;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StExec: begin
                    retired_q <= retired_q + 16'd1;
                    state_q   <= bus.halt_req ? StHalt : StFetch;
                end
                StHalt: begin
                    if (!bus.halt_req) state_q <= StFetch;
                end
                StFault: state_q <= StFault;
                default: state_q <= StInit;
            endcase
        end
    end

    logic jump;
    logic mem_req, pc_reset, pc_load, pc_inc, a_load, a_sel, d_load, m_write;

    always_comb begin
        jump     = (ir_q[2] & bus.ng) | (ir_q[1] & bus.zr) | (ir_q[0] & ~bus.ng & ~bus.zr);
        mem_req  = 1'b0;
        pc_reset = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        a_load   = 1'b0;
        a_sel    = 1'b0;
        d_load   = 1'b0;
        m_write  = 1'b0;
        case (state_q)
            StInit:  pc_reset = 1'b1;
            StFetch: mem_req = 1'b1;
            StExec: begin
                if (!ir_q[15]) begin
                    a_load = 1'b1;
                    pc_inc = 1'b1;
                end else begin
                    // C-instruction: dest bits pick registers, jump bits gate the PC load
                    a_load  = ir_q[5];
                    a_sel   = 1'b1;
                    d_load  = ir_q[4];
                    m_write = ir_q[3];
                    pc_load = jump;
                    pc_inc  = ~jump;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_req  = mem_req;
    assign bus.pc_reset = pc_reset;
    assign bus.pc_load  = pc_load;
    assign bus.pc_inc   = pc_inc;
    assign bus.a_load   = a_load;
    assign bus.a_sel    = a_sel;
    assign bus.d_load   = d_load;
    assign bus.m_write  = m_write;
    assign bus.ir       = ir_q;
    assign bus.retired  = retired_q;
    assign bus.halted   = (state_q == StHalt);
    assign bus.fault    = fault_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/execute controller for the 16-bit CPU. It sequences the PC through its load, inc and reset controls, fetches instructions from instruction memory with a valid handshake, and holds the instruction register. It decodes A- and C-instructions into register-load and memory-write strobes, and resolves jumps from the ALU zr/ng flags. It sits between instruction memory, PC, A/D registers and the ALU.

Parameters:
TIMEOUT, 15, maximum FETCH cycles without instr_valid before entering FAULT (1..255)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
instr  input  16  instruction word from instruction memory
instr_valid  input  1  instr is valid this cycle (sampled only while mem_req=1)
zr  input  1  ALU zero flag, for the instruction currently in EXEC
ng  input  1  ALU negative flag, for the instruction currently in EXEC
halt_req  input  1  request to stop after the current instruction
mem_req  output  1  instruction fetch request
ir  output  16  instruction register
pc_reset  output  1  PC clear strobe
pc_load  output  1  PC load-from-A strobe
pc_inc  output  1  PC increment strobe
a_load  output  1  A register load strobe
a_sel  output  1  A source: 0 = ir[14:0] zero-extended, 1 = ALU out
d_load  output  1  D register load strobe
m_write  output  1  data memory write strobe
halted  output  1  high while in HALT
fault  output  1  sticky fetch-timeout flag
retired  output  16  count of completed instructions, wraps 0xFFFF->0x0000

Behaviour:
- States: INIT, FETCH, EXEC, HALT, FAULT. Registered: state, ir, wait counter, fault, retired. All strobes are combinational from state, ir, instr_valid, zr and ng.
- reset=0 at a posedge, from any state and mid-fetch included: state=INIT, ir=0, retired=0, fault=0, wait counter=0.
- INIT: pc_reset=1 and all other strobes 0. Unconditionally goes to FETCH, so pc_reset is high for exactly one cycle after reset release.
- FETCH: mem_req=1.
  - If instr_valid=1: the bench sees ir_load internally; ir<=instr; go to EXEC; wait counter cleared.
  - Otherwise the wait counter increments. When it reaches TIMEOUT, go to FAULT.
  - With a zero-wait memory an instruction takes 2 cycles (FETCH, EXEC).
- EXEC, A-instruction (ir[15]=0): a_load=1, a_sel=0, pc_inc=1.
- EXEC, C-instruction (ir[15]=1):
  - Loads: a_load=ir[5], a_sel=1, d_load=ir[4], m_write=ir[3].
  - jump=(ir[2]&ng)|(ir[1]&zr)|(ir[0]&~ng&~zr).
  - If jump=1: pc_load=1, pc_inc=0. Otherwise pc_inc=1.
- pc_load and pc_inc are mutually exclusive; pc_load has priority. pc_reset is never high with either of them.
- EXEC always lasts one cycle and increments retired (mod 2^16).
- Next state after EXEC: HALT if halt_req=1 in that cycle, else FETCH.
- HALT: halted=1 and all strobes 0. Goes to FETCH on the first cycle halt_req=0. halt_req asserted in FETCH has no effect until the instruction retires.
- FAULT: fault=1 and all strobes 0. Exits only via reset.
- Strobes are 0 in every state or condition not listed above.
- Outside FETCH, instr and instr_valid are ignored.

Test Plan:
- Reset held low 3 cycles, then released → one cycle with pc_reset=1; next cycle mem_req=1; ir=0, retired=0.
- instr=0x0007 with zero-wait valid → EXEC cycle has a_load=1, a_sel=0, pc_inc=1, pc_load=0; retired=1; mem_req=1 again next cycle.
- instr=0xE307 (unconditional jump) with zr=0, ng=0 → pc_load=1, pc_inc=0. instr=0xE302 (JEQ) with zr=0 → pc_inc=1; with zr=1 → pc_load=1.
- instr=0xEC38 (dest AMD) → a_load=1, a_sel=1, d_load=1, m_write=1 in EXEC. instr_valid delayed 5 cycles → mem_req high for 6 cycles, no fault.
- instr_valid held low with TIMEOUT=15 → fault=1 after 15 FETCH cycles; strobes stay 0; reset low clears fault and the sequencer restarts from INIT.
- halt_req=1 during EXEC → halted=1 next cycle and holds while halt_req=1; release → FETCH. Reset asserted mid-FETCH → INIT next cycle. 65536 retirements → retired wraps to 0x0000.
